// File: rtl/bank_cmd_arbiter_pkg.sv
// Shared types and defaults for the DRAM command-port arbiter.
// Holds the direction/turnaround state encoding and command-class decode.
package bank_cmd_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_READ    = 3'd0,
        ST_RTW     = 3'd1,
        ST_WRITE   = 3'd2,
        ST_WTR     = 3'd3,
        ST_REFRESH = 3'd4
    } arb_state_t;

    localparam int DEFAULT_READ_TIME  = 32;
    localparam int DEFAULT_WRITE_TIME = 16;
    localparam int DEFAULT_TRTW       = 2;
    localparam int DEFAULT_TWTR       = 4;
    localparam int DEFAULT_TRRD       = 2;

    function automatic logic is_act(input logic is_cmd, input logic ras,
                                    input logic cas, input logic we);
        return is_cmd & ras & ~cas & ~we;
    endfunction

endpackage

// File: rtl/bank_cmd_arbiter_rr_chooser.sv
// Round-robin chooser: first requester at or after last+1, wrapping.
// N must be a power of two so the index arithmetic wraps naturally.
module rr_chooser #(
    parameter int N = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          ce,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] last;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            last <= IW'(N - 1);
        end else if (ce && any) begin
            last <= idx;
        end
    end

    // k == N wraps to last itself, so the previous winner is checked last.
    always_comb begin
        logic [IW-1:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = last + IW'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        grant[idx] = any;
    end

endmodule

// File: rtl/bank_cmd_arbiter.sv
// Arbitrates bank machine commands and refresh onto the single PHY command slot,
// batching reads/writes with bounded starvation, turnaround gaps and tRRD spacing.
module bank_cmd_arbiter
    import bank_cmd_arbiter_pkg::*;
#(
    parameter int BABITS     = 3,
    parameter int ABITS      = 14,
    parameter int READ_TIME  = DEFAULT_READ_TIME,
    parameter int WRITE_TIME = DEFAULT_WRITE_TIME,
    parameter int TRTW       = DEFAULT_TRTW,
    parameter int TWTR       = DEFAULT_TWTR,
    parameter int TRRD       = DEFAULT_TRRD,
    localparam int NBANKS    = 2 ** BABITS
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [NBANKS-1:0]       bm_cmd_valid,
    output logic [NBANKS-1:0]       bm_cmd_ready,
    input  logic [NBANKS*ABITS-1:0] bm_cmd_a,
    input  logic [NBANKS-1:0]       bm_cmd_cas,
    input  logic [NBANKS-1:0]       bm_cmd_ras,
    input  logic [NBANKS-1:0]       bm_cmd_we,
    input  logic [NBANKS-1:0]       bm_cmd_is_cmd,
    input  logic [NBANKS-1:0]       bm_cmd_is_read,
    input  logic [NBANKS-1:0]       bm_cmd_is_write,
    input  logic                    ref_valid,
    output logic                    ref_ready,
    input  logic [ABITS-1:0]        ref_a,
    input  logic                    ref_cas,
    input  logic                    ref_ras,
    input  logic                    ref_we,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ABITS-1:0]        out_a,
    output logic [BABITS-1:0]       out_ba,
    output logic                    out_cas,
    output logic                    out_ras,
    output logic                    out_we,
    output logic                    out_is_read,
    output logic                    out_is_write
);

    localparam int BUD_MAX = (READ_TIME > WRITE_TIME) ? READ_TIME : WRITE_TIME;
    localparam int TRN_MAX = (TRTW > TWTR) ? TRTW : TWTR;
    localparam int BUD_W   = $clog2(BUD_MAX + 1);
    localparam int TRN_W   = $clog2(TRN_MAX + 1);
    localparam int TRRD_W  = $clog2(TRRD + 1);

    arb_state_t          state, state_nxt;
    logic [BUD_W-1:0]    budget;
    logic [TRN_W-1:0]    turn;
    logic [TRRD_W-1:0]   trrd;
    logic [NBANKS-1:0]   elig, grant;
    logic [BABITS-1:0]   gidx;
    logic                any_elig, rd_pend, wr_pend;
    logic                sel_act, bank_accept, act_accept;

    assign rd_pend     = |(bm_cmd_valid & bm_cmd_is_read);
    assign wr_pend     = |(bm_cmd_valid & bm_cmd_is_write);
    assign bank_accept = out_valid & out_ready & (state != ST_REFRESH);
    assign act_accept  = bank_accept & sel_act;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NBANKS; i++) begin
            case (state)
                ST_READ:        elig[i] = bm_cmd_is_cmd[i] | bm_cmd_is_read[i];
                ST_WRITE:       elig[i] = bm_cmd_is_cmd[i] | bm_cmd_is_write[i];
                ST_RTW, ST_WTR: elig[i] = bm_cmd_is_cmd[i];
                default:        elig[i] = 1'b0;
            endcase
            if (trrd != '0 && is_act(bm_cmd_is_cmd[i], bm_cmd_ras[i], bm_cmd_cas[i], bm_cmd_we[i]))
                elig[i] = 1'b0;
            elig[i] = elig[i] & bm_cmd_valid[i];
        end
    end

    rr_chooser #(.N(NBANKS)) u_chooser (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .ce      (bank_accept),
        .req     (elig),
        .grant   (grant),
        .idx     (gidx),
        .any     (any_elig)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= ST_READ;
        else         state <= state_nxt;
    end

    // Refresh preempts every other state; banks still win the cycle it is seen.
    always_comb begin
        state_nxt = state;
        if (state != ST_REFRESH && ref_valid) begin
            state_nxt = ST_REFRESH;
        end else begin
            case (state)
                ST_READ:    if (wr_pend && (!rd_pend || budget == '0)) state_nxt = ST_RTW;
                ST_WRITE:   if (rd_pend && (!wr_pend || budget == '0)) state_nxt = ST_WTR;
                ST_RTW:     if (turn == '0) state_nxt = ST_WRITE;
                ST_WTR:     if (turn == '0) state_nxt = ST_READ;
                ST_REFRESH: if (ref_valid && out_ready) state_nxt = ST_READ;
                default:    state_nxt = ST_READ;
            endcase
        end
    end

    always_comb begin
        out_valid    = 1'b0;
        out_a        = '0;
        out_ba       = '0;
        out_cas      = 1'b0;
        out_ras      = 1'b0;
        out_we       = 1'b0;
        out_is_read  = 1'b0;
        out_is_write = 1'b0;
        ref_ready    = 1'b0;
        bm_cmd_ready = '0;
        sel_act      = 1'b0;
        if (state == ST_REFRESH) begin
            out_valid = ref_valid;
            out_a     = ref_a;
            out_cas   = ref_cas;
            out_ras   = ref_ras;
            out_we    = ref_we;
            ref_ready = out_ready;
        end else begin
            out_valid    = any_elig;
            out_ba       = gidx;
            bm_cmd_ready = grant & {NBANKS{out_ready}};
            for (int i = 0; i < NBANKS; i++) begin
                if (grant[i]) begin
                    out_a        = bm_cmd_a[i*ABITS +: ABITS];
                    out_cas      = bm_cmd_cas[i];
                    out_ras      = bm_cmd_ras[i];
                    out_we       = bm_cmd_we[i];
                    out_is_read  = bm_cmd_is_read[i];
                    out_is_write = bm_cmd_is_write[i];
                    sel_act      = is_act(bm_cmd_is_cmd[i], bm_cmd_ras[i], bm_cmd_cas[i], bm_cmd_we[i]);
                end
            end
        end
    end

    // Budget reloads on direction entry, drains only while the other side waits.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            budget <= BUD_W'(READ_TIME);
        end else if (state_nxt == ST_READ && state != ST_READ) begin
            budget <= BUD_W'(READ_TIME);
        end else if (state_nxt == ST_WRITE && state != ST_WRITE) begin
            budget <= BUD_W'(WRITE_TIME);
        end else if (((state == ST_READ && wr_pend) || (state == ST_WRITE && rd_pend))
                     && budget != '0) begin
            budget <= budget - BUD_W'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            turn <= '0;
        end else if (state_nxt == ST_RTW && state != ST_RTW) begin
            turn <= TRN_W'(TRTW - 1);
        end else if (state_nxt == ST_WTR && state != ST_WTR) begin
            turn <= TRN_W'(TWTR - 1);
        end else if (turn != '0) begin
            turn <= turn - TRN_W'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            trrd <= '0;
        end else if (act_accept) begin
            trrd <= TRRD_W'(TRRD - 1);
        end else if (trrd != '0) begin
            trrd <= trrd - TRRD_W'(1);
        end
    end

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Directed scoreboard bench for bank_cmd_arbiter: stimulus queues expected
// transfers (cycle + payload), a negedge monitor pops and compares them.
module tb_bank_cmd_arbiter;
    localparam int BABITS = 3;
    localparam int ABITS  = 14;
    localparam int NB     = 8;

    localparam logic [4:0] F_RD  = 5'b10010;  // {cas, ras, we, rd, wr}
    localparam logic [4:0] F_WR  = 5'b10101;
    localparam logic [4:0] F_ACT = 5'b01000;
    localparam logic [4:0] F_REF = 5'b11000;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst = 1'b1;
    logic [NB-1:0]        bm_cmd_valid, bm_cmd_ready, bm_cmd_cas, bm_cmd_ras, bm_cmd_we;
    logic [NB-1:0]        bm_cmd_is_cmd, bm_cmd_is_read, bm_cmd_is_write;
    logic [NB*ABITS-1:0]  bm_cmd_a;
    logic                 ref_valid, ref_ready, ref_cas, ref_ras, ref_we;
    logic [ABITS-1:0]     ref_a;
    logic                 out_valid, out_ready, out_cas, out_ras, out_we, out_is_read, out_is_write;
    logic [ABITS-1:0]     out_a;
    logic [BABITS-1:0]    out_ba;

    bank_cmd_arbiter dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .bm_cmd_valid   (bm_cmd_valid),
        .bm_cmd_ready   (bm_cmd_ready),
        .bm_cmd_a       (bm_cmd_a),
        .bm_cmd_cas     (bm_cmd_cas),
        .bm_cmd_ras     (bm_cmd_ras),
        .bm_cmd_we      (bm_cmd_we),
        .bm_cmd_is_cmd  (bm_cmd_is_cmd),
        .bm_cmd_is_read (bm_cmd_is_read),
        .bm_cmd_is_write(bm_cmd_is_write),
        .ref_valid      (ref_valid),
        .ref_ready      (ref_ready),
        .ref_a          (ref_a),
        .ref_cas        (ref_cas),
        .ref_ras        (ref_ras),
        .ref_we         (ref_we),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_a          (out_a),
        .out_ba         (out_ba),
        .out_cas        (out_cas),
        .out_ras        (out_ras),
        .out_we         (out_we),
        .out_is_read    (out_is_read),
        .out_is_write   (out_is_write)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [30:0] pay;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [13:0] addr_of(input int b);
        return 14'h100 + 14'(b);
    endfunction

    function automatic logic [30:0] pay(input int ba, input logic [13:0] a, input logic [4:0] f,
                                        input logic [7:0] rdy, input logic rref);
        return {3'(ba), a, f, rdy, rref};
    endfunction

    task automatic push_bank(input int c, input int b, input logic [4:0] f);
        exp_t e;
        e.cyc = c;
        e.pay = pay(b, addr_of(b), f, 8'(1 << b), 1'b0);
        sbq.push_back(e);
    endtask

    task automatic set_bank(input int b, input logic [4:0] f);
        bm_cmd_valid[b]    = 1'b1;
        bm_cmd_cas[b]      = f[4];
        bm_cmd_ras[b]      = f[3];
        bm_cmd_we[b]       = f[2];
        bm_cmd_is_read[b]  = f[1];
        bm_cmd_is_write[b] = f[0];
        bm_cmd_is_cmd[b]   = ~(f[1] | f[0]);
    endtask

    task automatic clr_bank(input int b);
        bm_cmd_valid[b]    = 1'b0;
        bm_cmd_cas[b]      = 1'b0;
        bm_cmd_ras[b]      = 1'b0;
        bm_cmd_we[b]       = 1'b0;
        bm_cmd_is_read[b]  = 1'b0;
        bm_cmd_is_write[b] = 1'b0;
        bm_cmd_is_cmd[b]   = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Monitor: every accepted transfer must match the next queued expectation.
    always @(negedge sys_clk) begin
        if (!sys_rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got ba=%0d a=0x%0h at cycle %0d, expected no transfer",
                         out_ba, out_a, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("xfer_cycle", 64'(cyc), 64'(e.cyc));
                check("xfer_payload",
                      64'({out_ba, out_a, out_cas, out_ras, out_we, out_is_read, out_is_write,
                           bm_cmd_ready, ref_ready}), 64'(e.pay));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        int t0;
        int ord[6] = '{0, 2, 5, 0, 2, 5};
        exp_t e;
        for (int i = 0; i < NB; i++) begin
            clr_bank(i);
            bm_cmd_a[i*ABITS +: ABITS] = addr_of(i);
        end
        ref_valid = 1'b0;
        ref_a     = 14'h0400;
        ref_cas   = 1'b1;
        ref_ras   = 1'b1;
        ref_we    = 1'b0;
        out_ready = 1'b1;
        sys_rst   = 1'b1;
        step(2);
        sys_rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_ref_ready", 64'(ref_ready), 64'd0);
        check("rst_bm_ready", 64'(bm_cmd_ready), 64'd0);
        check("rst_out_fields",
              64'({out_a, out_ba, out_cas, out_ras, out_we, out_is_read, out_is_write}), 64'd0);

        // Round-robin among banks 0, 2, 5
        step(1);
        t0 = cyc;
        set_bank(0, F_RD); set_bank(2, F_RD); set_bank(5, F_RD);
        for (int k = 0; k < 6; k++) push_bank(t0 + k, ord[k], F_RD);
        step(6);
        clr_bank(0); clr_bank(2); clr_bank(5);

        // Single bank 3 read, zero latency
        set_bank(3, F_RD);
        t0 = cyc;
        push_bank(t0, 3, F_RD);
        step(1);
        clr_bank(3);

        // Selection held while out_ready is low
        out_ready = 1'b0;
        set_bank(2, F_RD); set_bank(6, F_RD);
        #2;
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_ba", 64'(out_ba), 64'd6);
        check("hold_bm_ready", 64'(bm_cmd_ready), 64'd0);
        step(1);
        check("hold_ba_stable", 64'(out_ba), 64'd6);
        out_ready = 1'b1;
        t0 = cyc;
        push_bank(t0, 6, F_RD);
        push_bank(t0 + 1, 2, F_RD);
        step(1);
        clr_bank(6);
        step(1);
        clr_bank(2);

        // Read budget expiry, RTW gap, write, WTR gap, read
        set_bank(1, F_RD); set_bank(4, F_WR);
        t0 = cyc;
        for (int k = 0; k <= 32; k++) push_bank(t0 + k, 1, F_RD);
        push_bank(t0 + 35, 4, F_WR);
        push_bank(t0 + 41, 1, F_RD);
        step(36);
        clr_bank(4);
        step(6);
        clr_bank(1);

        // tRRD spacing between activates
        set_bank(0, F_ACT); set_bank(1, F_ACT);
        t0 = cyc;
        push_bank(t0, 0, F_ACT);
        push_bank(t0 + 2, 1, F_ACT);
        step(1);
        clr_bank(0);
        step(2);
        clr_bank(1);

        // Refresh preempting WRITE with a bank still pending
        set_bank(2, F_WR);
        t0 = cyc;
        push_bank(t0 + 3, 2, F_WR);
        push_bank(t0 + 4, 2, F_WR);
        step(4);
        ref_valid = 1'b1;
        e.cyc = t0 + 5;
        e.pay = pay(0, 14'h0400, F_REF, 8'h00, 1'b1);
        sbq.push_back(e);
        step(2);
        ref_valid = 1'b0;
        clr_bank(2);
        set_bank(7, F_RD);
        push_bank(t0 + 6, 7, F_RD);
        step(1);
        clr_bank(7);

        // Asynchronous reset in the middle of WTR
        set_bank(3, F_WR);
        t0 = cyc;
        push_bank(t0 + 3, 3, F_WR);
        step(4);
        clr_bank(3);
        set_bank(5, F_RD); set_bank(0, F_RD);
        step(1);
        #2;
        check("wtr_blocks_rd", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        sys_rst   = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd1);
        check("arst_ba", 64'(out_ba), 64'd0);
        check("arst_is_read", 64'(out_is_read), 64'd1);
        check("arst_bm_ready", 64'(bm_cmd_ready), 64'd0);
        step(1);
        sys_rst   = 1'b0;
        out_ready = 1'b1;
        push_bank(t0 + 6, 0, F_RD);
        push_bank(t0 + 7, 5, F_RD);
        step(1);
        clr_bank(0);
        step(1);
        clr_bank(5);

        step(3);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
